// File: rtl/loot_pkg.sv
// loot_pkg: slot state type, spawn table and value-generator constants for loot_manager
package loot_pkg;
  typedef enum logic [1:0] {EMPTY, PRESENT, OFFER, WAIT} loot_state_t;
  localparam int ITEM_SIZE = 16;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;
  localparam logic [9:0] LOOT_X [8] = '{10'd100, 10'd116, 10'd300, 10'd400, 10'd500, 10'd200, 10'd50, 10'd600};
  localparam logic [9:0] LOOT_Y [8] = '{10'd200, 10'd200, 10'd200, 10'd300, 10'd100, 10'd400, 10'd350, 10'd250};
  function automatic logic [1:0] item_value(input logic [7:0] lfsr);
    return (lfsr[1:0] == 2'd0) ? 2'd1 : lfsr[1:0];
  endfunction
endpackage

// File: rtl/collision.sv
// collision: overlap test between two SIZE x SIZE boxes given by their top-left corners
module collision #(
  parameter int SIZE = 16
) (
  input  logic [10:0] ax,
  input  logic [10:0] ay,
  input  logic [10:0] bx,
  input  logic [10:0] by,
  output logic        hit
);
  assign hit = (ax < bx + 11'(SIZE)) && (bx < ax + 11'(SIZE)) &&
               (ay < by + 11'(SIZE)) && (by < ay + 11'(SIZE));
endmodule

// File: rtl/loot_lfsr.sv
// loot_lfsr: 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) that reseeds on clear
module loot_lfsr import loot_pkg::*; #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       FrameClk,
  input  logic       Reset,
  input  logic       clear,
  input  logic       advance,
  output logic [7:0] lfsr
);
  always_ff @(posedge FrameClk or posedge Reset)
    if (Reset) lfsr <= SEED;
    else if (clear) lfsr <= SEED;
    else if (advance) lfsr <= {lfsr[6:0], ^(lfsr & LFSR_TAPS)};
endmodule

// File: rtl/loot_manager.sv
// loot_manager: offers overlapping loot to players, retires it on Collected, respawns it and renders it
module loot_manager import loot_pkg::*; #(
  parameter int         NUM_ITEMS      = 4,
  parameter int         RESPAWN_FRAMES = 120,
  parameter logic [7:0] LFSR_SEED      = 8'hA5
) (
  input  logic       FrameClk,
  input  logic       Reset,
  input  logic       SpawnEnable,
  input  logic [9:0] P1X,
  input  logic [9:0] P1Y,
  input  logic [9:0] P2X,
  input  logic [9:0] P2Y,
  input  logic [4:0] P1HbOffset,
  input  logic [4:0] P2HbOffset,
  input  logic       P1Collected,
  input  logic       P2Collected,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  output logic [1:0] P1Collect,
  output logic [1:0] P2Collect,
  output logic       LootPixel,
  output logic [1:0] LootValue,
  output logic [3:0] PixelX,
  output logic [3:0] PixelY
);
  loot_state_t state [NUM_ITEMS];
  logic [1:0] value [NUM_ITEMS];
  logic [7:0] timer [NUM_ITEMS];
  logic owner [NUM_ITEMS];
  logic [7:0] lfsr;
  logic [10:0] hb1x, hb1y, hb2x, hb2y;
  logic [NUM_ITEMS-1:0] hit1, hit2, present, busy1, busy2, in_box, req1, req2, gnt1, gnt2;
  logic [1:0] val1, val2;
  assign hb1x = 11'(P1X) + 11'(P1HbOffset);
  assign hb1y = 11'(P1Y) + 11'(ITEM_SIZE);
  assign hb2x = 11'(P2X) + 11'(P2HbOffset);
  assign hb2y = 11'(P2Y) + 11'(ITEM_SIZE);
  loot_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .FrameClk(FrameClk), .Reset(Reset), .clear(!SpawnEnable), .advance(SpawnEnable), .lfsr(lfsr)
  );
  for (genvar i = 0; i < NUM_ITEMS; i++) begin : g_slot
    collision #(.SIZE(ITEM_SIZE)) u_c1 (
      .ax(hb1x), .ay(hb1y), .bx(11'(LOOT_X[i])), .by(11'(LOOT_Y[i])), .hit(hit1[i])
    );
    collision #(.SIZE(ITEM_SIZE)) u_c2 (
      .ax(hb2x), .ay(hb2y), .bx(11'(LOOT_X[i])), .by(11'(LOOT_Y[i])), .hit(hit2[i])
    );
    assign present[i] = state[i] == PRESENT;
    assign busy1[i] = (state[i] == OFFER || state[i] == WAIT) && !owner[i];
    assign busy2[i] = (state[i] == OFFER || state[i] == WAIT) && owner[i];
    assign in_box[i] = DrawX >= LOOT_X[i] && 11'(DrawX) < 11'(LOOT_X[i]) + 11'(ITEM_SIZE) &&
                       DrawY >= LOOT_Y[i] && 11'(DrawY) < 11'(LOOT_Y[i]) + 11'(ITEM_SIZE);
  end
  // lowest-index grant per player; P2 may not take the slot P1 was just granted
  assign req1 = present & hit1 & {NUM_ITEMS{~|busy1}};
  assign gnt1 = req1 & (~req1 + NUM_ITEMS'(1));
  assign req2 = present & hit2 & ~gnt1 & {NUM_ITEMS{~|busy2}};
  assign gnt2 = req2 & (~req2 + NUM_ITEMS'(1));
  always_comb begin
    val1 = '0;
    val2 = '0;
    LootPixel = 1'b0;
    LootValue = '0;
    PixelX = '0;
    PixelY = '0;
    for (int j = NUM_ITEMS - 1; j >= 0; j--) begin
      val1 = gnt1[j] ? value[j] : val1;
      val2 = gnt2[j] ? value[j] : val2;
      if (SpawnEnable && state[j] != EMPTY && in_box[j]) begin
        LootPixel = 1'b1;
        LootValue = value[j];
        PixelX = 4'(DrawX - LOOT_X[j]);
        PixelY = 4'(DrawY - LOOT_Y[j]);
      end
    end
  end
  always_ff @(posedge FrameClk or posedge Reset)
    if (Reset) begin
      P1Collect <= '0;
      P2Collect <= '0;
      for (int j = 0; j < NUM_ITEMS; j++) begin
        state[j] <= PRESENT; value[j] <= 2'd1; timer[j] <= '0; owner[j] <= 1'b0;
      end
    end else if (!SpawnEnable) begin
      P1Collect <= '0;
      P2Collect <= '0;
      for (int j = 0; j < NUM_ITEMS; j++) begin
        state[j] <= PRESENT; value[j] <= 2'd1; timer[j] <= '0; owner[j] <= 1'b0;
      end
    end else begin
      P1Collect <= val1;
      P2Collect <= val2;
      for (int j = 0; j < NUM_ITEMS; j++)
        case (state[j])
          PRESENT: if (gnt1[j] || gnt2[j]) begin
            state[j] <= OFFER;
            owner[j] <= gnt2[j];
          end
          OFFER: state[j] <= WAIT;
          WAIT: if (owner[j] ? P2Collected : P1Collected) begin
            state[j] <= EMPTY;
            timer[j] <= 8'(RESPAWN_FRAMES);
          end else state[j] <= PRESENT;
          default: if (timer[j] <= 8'd1) begin
            state[j] <= PRESENT;
            value[j] <= item_value(lfsr);
            timer[j] <= '0;
          end else timer[j] <= timer[j] - 8'd1;
        endcase
    end
endmodule

// File: tb/tb_loot_manager.sv
// tb_loot_manager: scoreboard bench for the loot offer/collect handshake and loot rendering
module tb_loot_manager;
  import loot_pkg::*;
  logic FrameClk = 1'b0, Reset = 1'b0, SpawnEnable = 1'b1;
  logic [9:0] P1X, P1Y, P2X, P2Y, DrawX, DrawY;
  logic [4:0] P1HbOffset, P2HbOffset;
  logic P1Collected, P2Collected, LootPixel;
  logic [1:0] P1Collect, P2Collect, LootValue;
  logic [3:0] PixelX, PixelY;
  int cyc = 0, n_checks = 0, n_fail = 0, k;
  bit p1_acc = 0, p2_acc = 0, p1_stray = 0;
  typedef struct { int player; int frame; logic [1:0] val; bit anyv; } offer_t;
  typedef struct { string name; logic pix; logic [1:0] val; logic [3:0] px; logic [3:0] py; bit anyv; } probe_t;
  offer_t oq[$];
  probe_t rq[$];

  loot_manager dut (
    .FrameClk(FrameClk), .Reset(Reset), .SpawnEnable(SpawnEnable),
    .P1X(P1X), .P1Y(P1Y), .P2X(P2X), .P2Y(P2Y),
    .P1HbOffset(P1HbOffset), .P2HbOffset(P2HbOffset),
    .P1Collected(P1Collected), .P2Collected(P2Collected),
    .DrawX(DrawX), .DrawY(DrawY),
    .P1Collect(P1Collect), .P2Collect(P2Collect),
    .LootPixel(LootPixel), .LootValue(LootValue), .PixelX(PixelX), .PixelY(PixelY)
  );

  always #5 FrameClk = ~FrameClk;
  always @(posedge FrameClk) cyc++;

  task automatic step();
    @(posedge FrameClk);
    #1;
  endtask

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic expect_offer(input int pl, input int frame, input logic [1:0] v, input bit anyv = 0);
    offer_t e;
    e.player = pl; e.frame = frame; e.val = v; e.anyv = anyv;
    oq.push_back(e);
  endtask

  task automatic probe(input string name, input int x, input int y, input logic pix,
                       input logic [1:0] v, input int px, input int py, input bit anyv = 0);
    probe_t p;
    DrawX = 10'(x);
    DrawY = 10'(y);
    p.name = name; p.pix = pix; p.val = v; p.px = 4'(px); p.py = 4'(py); p.anyv = anyv;
    rq.push_back(p);
    step();
  endtask

  task automatic place1(input int hx, input int hy);
    P1X = 10'(hx);
    P1Y = 10'(hy - 16);
  endtask

  task automatic place2(input int hx, input int hy);
    P2X = 10'(hx - 16);
    P2Y = 10'(hy - 16);
  endtask

  task automatic check_offer(input int pl, input logic [1:0] got);
    offer_t e;
    if (got == 2'd0) return;
    n_checks++;
    if (oq.size() == 0) begin
      n_fail++;
      $display("FAIL offer_unexpected: P%0d offered %0d at frame %0d, expected no offer", pl, got, cyc);
      return;
    end
    e = oq.pop_front();
    if (e.player != pl || e.frame != cyc || (!e.anyv && got != e.val)) begin
      n_fail++;
      $display("FAIL offer_P%0d: got P%0d value %0d frame %0d, expected P%0d value %0d frame %0d",
               e.player, pl, got, cyc, e.player, e.val, e.frame);
    end
  endtask

  // player model: registers Collected one frame after seeing an offer, if accepting
  initial begin
    bit last1 = 0, last2 = 0;
    P1Collected = 1'b0;
    P2Collected = 1'b0;
    forever begin
      @(posedge FrameClk);
      #2;
      P1Collected = (p1_acc && last1) || p1_stray;
      P2Collected = p2_acc && last2;
      last1 = P1Collect != 2'd0;
      last2 = P2Collect != 2'd0;
    end
  end

  // monitor: pops the scoreboard whenever an offer or a render probe is presented
  initial forever begin
    probe_t p;
    string ev;
    @(negedge FrameClk);
    while (oq.size() > 0 && oq[0].frame < cyc) begin
      n_checks++;
      n_fail++;
      $display("FAIL offer_missed: P%0d got no offer at frame %0d, expected value %0d",
               oq[0].player, oq[0].frame, oq[0].val);
      void'(oq.pop_front());
    end
    check_offer(1, P1Collect);
    check_offer(2, P2Collect);
    if (rq.size() > 0) begin
      p = rq.pop_front();
      ev = p.anyv ? "1..3" : $sformatf("%0d", p.val);
      n_checks++;
      if (LootPixel !== p.pix || PixelX !== p.px || PixelY !== p.py ||
          (p.anyv ? LootValue == 2'd0 : LootValue !== p.val)) begin
        n_fail++;
        $display("FAIL %s: got pix=%0d val=%0d px=%0d py=%0d, expected pix=%0d val=%s px=%0d py=%0d",
                 p.name, LootPixel, LootValue, PixelX, PixelY, p.pix, ev, p.px, p.py);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    P1HbOffset = 5'd0;
    P2HbOffset = 5'd16;
    place1(600, 16);
    place2(716, 16);
    DrawX = '0;
    DrawY = '0;
    #1 Reset = 1'b1;
    #1;
    check("reset_p1collect", int'(P1Collect), 0);
    check("reset_p2collect", int'(P2Collect), 0);
    step();
    step();
    Reset = 1'b0;
    check("reset_lfsr_seed", int'(dut.u_lfsr.lfsr), 'hA5);
    // reset state: every slot drawn with value 1
    probe("t1_slot0", LOOT_X[0] + 3, LOOT_Y[0] + 5, 1, 1, 3, 5);
    probe("t1_slot1_corner", LOOT_X[1] + 15, LOOT_Y[1] + 15, 1, 1, 15, 15);
    probe("t1_slot2_origin", LOOT_X[2], LOOT_Y[2], 1, 1, 0, 0);
    probe("t1_slot3", LOOT_X[3] + 8, LOOT_Y[3] + 2, 1, 1, 8, 2);
    probe("t1_right_edge", LOOT_X[3] + 16, LOOT_Y[3], 0, 0, 0, 0);
    probe("t1_bottom_edge", LOOT_X[3], LOOT_Y[3] + 16, 0, 0, 0, 0);
    repeat (10) step();
    // accepted pickup of slot 0, then respawn after 120 frames
    p1_acc = 1;
    place1(LOOT_X[0] - 10, LOOT_Y[0]);
    k = cyc + 1;
    expect_offer(1, k, 1);
    step();
    place1(600, 16);
    step();
    step();
    probe("t2_retired", LOOT_X[0] + 3, LOOT_Y[0] + 5, 0, 0, 0, 0);
    while (cyc < k + 121) step();
    probe("t2_still_empty", LOOT_X[0] + 3, LOOT_Y[0] + 5, 0, 0, 0, 0);
    probe("t2_respawned", LOOT_X[0] + 3, LOOT_Y[0] + 5, 1, 0, 3, 5, 1);
    p1_acc = 0;
    // refused pickup of slot 1: re-offered every third frame
    place1(LOOT_X[1] + 9, LOOT_Y[1]);
    k = cyc + 1;
    expect_offer(1, k, 1);
    expect_offer(1, k + 3, 1);
    expect_offer(1, k + 6, 1);
    while (cyc < k + 6) step();
    place1(600, 16);
    probe("t3_still_drawn", LOOT_X[1] + 4, LOOT_Y[1] + 4, 1, 1, 4, 4);
    repeat (3) step();
    // contested slot 2: P1 wins and accepts, P2 never offered
    p1_acc = 1;
    place1(LOOT_X[2] + 2, LOOT_Y[2] + 2);
    place2(LOOT_X[2] + 2, LOOT_Y[2] + 2);
    k = cyc + 1;
    expect_offer(1, k, 1);
    while (cyc < k + 3) step();
    place1(600, 16);
    place2(716, 16);
    probe("t4_contested_retired", LOOT_X[2] + 1, LOOT_Y[2] + 1, 0, 0, 0, 0);
    p1_acc = 0;
    // contested slot 3: P1 refuses and leaves, P2 then gets it and accepts
    p2_acc = 1;
    place1(LOOT_X[3], LOOT_Y[3]);
    place2(LOOT_X[3], LOOT_Y[3]);
    k = cyc + 1;
    expect_offer(1, k, 1);
    expect_offer(2, k + 3, 1);
    step();
    place1(600, 16);
    while (cyc < k + 3) step();
    place2(716, 16);
    while (cyc < k + 5) step();
    probe("t4_p2_retired", LOOT_X[3] + 1, LOOT_Y[3] + 1, 0, 0, 0, 0);
    // P2 over slots 0 and 1: slot 0 first, slot 1 after slot 0 resolves
    place2(LOOT_X[0] + 8, LOOT_Y[0]);
    k = cyc + 1;
    expect_offer(2, k, 0, 1);
    expect_offer(2, k + 3, 1);
    while (cyc < k + 3) step();
    place2(716, 16);
    while (cyc < k + 5) step();
    probe("t5_slot1_retired", LOOT_X[1] + 2, LOOT_Y[1] + 2, 0, 0, 0, 0);
    probe("t5_slot0_retired", LOOT_X[0] + 2, LOOT_Y[0] + 2, 0, 0, 0, 0);
    p2_acc = 0;
    // SpawnEnable low clears every slot and hides the render outputs
    SpawnEnable = 1'b0;
    step();
    probe("t6_gated", LOOT_X[1] + 2, LOOT_Y[1] + 2, 0, 0, 0, 0);
    SpawnEnable = 1'b1;
    probe("t6_cleared", LOOT_X[1] + 2, LOOT_Y[1] + 2, 1, 1, 2, 2);
    // abort during WAIT, followed by a late stray Collected
    place1(LOOT_X[0] - 4, LOOT_Y[0]);
    k = cyc + 1;
    expect_offer(1, k, 1);
    step();
    place1(600, 16);
    step();
    SpawnEnable = 1'b0;
    p1_stray = 1;
    step();
    SpawnEnable = 1'b1;
    step();
    p1_stray = 0;
    probe("t6_not_retired", LOOT_X[0] + 6, LOOT_Y[0] + 7, 1, 1, 6, 7);
    probe("t6_stray_ignored", LOOT_X[0] + 6, LOOT_Y[0] + 7, 1, 1, 6, 7);
    // asynchronous Reset in the middle of an offer
    place1(LOOT_X[1] + 9, LOOT_Y[1]);
    step();
    check("async_offer_before", int'(P1Collect), 1);
    Reset = 1'b1;
    #1;
    check("async_offer_cleared", int'(P1Collect), 0);
    check("async_lfsr_seed", int'(dut.u_lfsr.lfsr), 'hA5);
    place1(600, 16);
    step();
    Reset = 1'b0;
    probe("t7_after_reset", LOOT_X[1] + 2, LOOT_Y[1] + 2, 1, 1, 2, 2);
    repeat (4) step();
    check("scoreboard_drained", oq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
